// File: rtl/rnd_stc_vec.sv
// Vector mantissa rounder: LANES independent lanes, each truncating, rounding half-up,
// rounding nearest-even or stochastically rounding with a per-lane LFSR, behind one register stage.
module rnd_stc_vec #(
  parameter int LANES   = 4,
  parameter int WIDTH_I = 24,
  parameter int WIDTH_O = 4,
  parameter int NOISE_W = 6,
  parameter int SAT     = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*WIDTH_I-1:0]   i_num,
  input  logic [1:0]                 i_mode,
  input  logic                       i_seed_vld,
  input  logic [NOISE_W-1:0]         i_seed,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [LANES*WIDTH_O-1:0]   o_man,
  output logic [LANES-1:0]           o_ofl
);

  localparam int KW = WIDTH_O + NOISE_W;
  localparam int SW = KW + 1;
  localparam logic [NOISE_W-1:0] ONE     = NOISE_W'(1);
  localparam logic [NOISE_W-1:0] HALF    = {1'b1, {(NOISE_W-1){1'b0}}};
  localparam logic [NOISE_W-1:0] HALF_M1 = {1'b0, {(NOISE_W-1){1'b1}}};

  if (!(NOISE_W == 4 || NOISE_W == 6 || NOISE_W == 8) || LANES < 1 || WIDTH_O < 1) begin : g_bad_params
    $error("rnd_stc_vec: illegal parameters (NOISE_W must be 4/6/8, LANES>=1, WIDTH_O>=1)");
  end

  // Handshake: a beat is accepted on i_valid & o_ready; the output beat is consumed on
  // o_valid & i_ready. o_ready is high whenever the output register is empty or draining.
  logic                     valid_q;
  logic [LANES*WIDTH_O-1:0] man_q;
  logic [LANES-1:0]         ofl_q;
  logic [LANES*WIDTH_O-1:0] man_d;
  logic [LANES-1:0]         ofl_d;
  logic                     accept;
  logic [NOISE_W-1:0]       seed_base;

  assign o_ready   = !valid_q | i_ready;
  assign accept    = i_valid & o_ready;
  assign seed_base = (i_seed == '0) ? ONE : i_seed;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int ROT = l % NOISE_W;
    localparam logic [NOISE_W-1:0] RST_SEED = ONE << ROT;

    logic [KW-1:0]      kept;
    logic [NOISE_W-1:0] lfsr_q;
    logic [NOISE_W-1:0] lfsr_d;
    logic [NOISE_W-1:0] seed_rot;
    logic [NOISE_W-1:0] addend;
    logic [SW-1:0]      sum;
    logic [WIDTH_O-1:0] res;
    logic               fb;

    if (WIDTH_I >= KW) begin : g_trim
      assign kept = i_num[l*WIDTH_I + (WIDTH_I-KW) +: KW];
      if (WIDTH_I > KW) begin : g_drop
        logic lane_unused;
        assign lane_unused = ^i_num[l*WIDTH_I +: (WIDTH_I-KW)];
      end
    end else begin : g_pad
      assign kept = {i_num[l*WIDTH_I +: WIDTH_I], {(KW-WIDTH_I){1'b0}}};
    end

    if (ROT == 0) begin : g_rot0
      assign seed_rot = seed_base;
    end else begin : g_rotn
      assign seed_rot = {seed_base[NOISE_W-1-ROT:0], seed_base[NOISE_W-1 -: ROT]};
    end

    if (NOISE_W == 8) begin : g_fb8
      assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end else if (NOISE_W == 6) begin : g_fb6
      assign fb = lfsr_q[5] ^ lfsr_q[4];
    end else begin : g_fb4
      assign fb = lfsr_q[3] ^ lfsr_q[2];
    end

    always_comb begin
      addend = '0;
      case (i_mode)
        2'b00: addend = '0;
        2'b01: addend = HALF;
        2'b10: addend = lfsr_q;
        2'b11: addend = HALF_M1 + {{(NOISE_W-1){1'b0}}, kept[NOISE_W]};
        default: addend = '0;
      endcase
    end

    assign sum = {1'b0, kept} + SW'(addend);
    assign res = sum[KW-1 -: WIDTH_O];

    assign ofl_d[l] = sum[SW-1];
    assign man_d[l*WIDTH_O +: WIDTH_O] = ((SAT != 0) && sum[SW-1]) ? {WIDTH_O{1'b1}} : res;

    // A seed load wins over the per-beat advance; the beat itself uses the old state.
    always_comb begin
      lfsr_d = lfsr_q;
      if (i_seed_vld) begin
        lfsr_d = seed_rot;
      end else if (accept) begin
        lfsr_d = {lfsr_q[NOISE_W-2:0], fb};
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        lfsr_q <= RST_SEED;
      end else begin
        lfsr_q <= lfsr_d;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      man_q   <= '0;
      ofl_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      man_q   <= man_d;
      ofl_q   <= ofl_d;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_man   = man_q;
  assign o_ofl   = ofl_q;

endmodule

// File: tb/tb_rnd_stc_vec.sv
// Scoreboard bench for rnd_stc_vec: two instances (saturating and wrapping) share stimulus;
// a driver pushes model predictions on accept, a monitor pops them on each output transfer.
module tb_rnd_stc_vec;
  localparam int LANES = 2;
  localparam int WI    = 8;
  localparam int WO    = 4;
  localparam int NW    = 4;
  localparam int EW    = 2*LANES*WO + LANES;
  localparam int MASK  = (1 << NW) - 1;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic                  i_valid;
  logic [LANES*WI-1:0]   i_num;
  logic [1:0]            i_mode;
  logic                  i_seed_vld;
  logic [NW-1:0]         i_seed;
  logic                  i_ready;
  logic                  o_ready_s, o_ready_w;
  logic                  o_valid_s, o_valid_w;
  logic [LANES*WO-1:0]   o_man_s, o_man_w;
  logic [LANES-1:0]      o_ofl_s, o_ofl_w;

  rnd_stc_vec #(.LANES(LANES), .WIDTH_I(WI), .WIDTH_O(WO), .NOISE_W(NW), .SAT(1)) dut_s (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_s), .i_num(i_num),
    .i_mode(i_mode), .i_seed_vld(i_seed_vld), .i_seed(i_seed), .o_valid(o_valid_s),
    .i_ready(i_ready), .o_man(o_man_s), .o_ofl(o_ofl_s));

  rnd_stc_vec #(.LANES(LANES), .WIDTH_I(WI), .WIDTH_O(WO), .NOISE_W(NW), .SAT(0)) dut_w (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_w), .i_num(i_num),
    .i_mode(i_mode), .i_seed_vld(i_seed_vld), .i_seed(i_seed), .o_valid(o_valid_w),
    .i_ready(i_ready), .o_man(o_man_w), .o_ofl(o_ofl_w));

  always #5 clk = ~clk;

  // Reference model state
  int            lfsr_m[LANES];
  bit            mdl_valid;
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            hold_pending = 0;
  logic [LANES*WO-1:0] held_man;
  logic [LANES-1:0]    held_ofl;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rotl(input int x, input int r);
    return ((x << r) | (x >> (NW - r))) & MASK;
  endfunction

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 3) ^ (s >> 2)) & 1;
    return ((s << 1) & MASK) | fb;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) lfsr_m[l] = rotl(1, l % NW);
    mdl_valid = 0;
  endtask

  // Rounding rule as arithmetic: add the mode's addend to the kept field, take the top bits.
  function automatic logic [EW-1:0] predict(input logic [LANES*WI-1:0] num, input logic [1:0] mode);
    int k, add, sum, ofl, res, man_s, man_w, ofls;
    man_s = 0; man_w = 0; ofls = 0;
    for (int l = 0; l < LANES; l++) begin
      k = int'((num >> (l*WI)) & 16'h00FF);
      case (mode)
        2'd0: add = 0;
        2'd1: add = 1 << (NW-1);
        2'd2: add = lfsr_m[l];
        default: add = (1 << (NW-1)) - 1 + ((k >> NW) & 1);
      endcase
      sum = k + add;
      ofl = (sum >= 256) ? 1 : 0;
      res = (sum >> NW) & 15;
      man_s |= (ofl != 0 ? 15 : res) << (l*WO);
      man_w |= res << (l*WO);
      ofls  |= ofl << l;
    end
    return EW'((ofls << 16) | (man_s << 8) | man_w);
  endfunction

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input bit v, input logic [LANES*WI-1:0] num, input logic [1:0] mode,
                       input bit sv, input logic [NW-1:0] seed, input bit rdy);
    bit exp_rdy, acc;
    i_valid = v; i_num = num; i_mode = mode; i_seed_vld = sv; i_seed = seed; i_ready = rdy;
    @(negedge clk);
    exp_rdy = !mdl_valid || rdy;
    check("o_ready", int'(o_ready_s), int'(exp_rdy));
    check("o_valid", int'(o_valid_s), int'(mdl_valid));
    acc = v && exp_rdy;
    if (acc) exp_q.push_back(predict(num, mode));
    for (int l = 0; l < LANES; l++) begin
      if (sv) lfsr_m[l] = rotl((seed == 0) ? 1 : int'(seed), l % NW);
      else if (acc) lfsr_m[l] = lfsr_next(lfsr_m[l]);
    end
    mdl_valid = acc ? 1'b1 : (rdy ? 1'b0 : mdl_valid);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 2'd0, 0, '0, 1);
  endtask

  task automatic pulse_reset();
    i_rst = 1; i_valid = 0; i_seed_vld = 0;
    #1;
    check("rst_valid", int'(o_valid_s), 0);
    check("rst_man", int'(o_man_s), 0);
    check("rst_ofl", int'(o_ofl_s), 0);
    exp_q.delete();
    hold_pending = 0;
    model_reset();
    @(posedge clk);
    #1;
    i_rst = 0;
  endtask

  // Monitor: compare on every output transfer, and check stability across stalls.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (hold_pending) begin
        check("stall_man", int'(o_man_s), int'(held_man));
        check("stall_ofl", int'(o_ofl_s), int'(held_ofl));
        check("stall_valid", int'(o_valid_s), 1);
        hold_pending = 0;
      end
      if (o_valid_s && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("man_sat", int'(o_man_s), int'(e[15:8]));
          check("man_wrap", int'(o_man_w), int'(e[7:0]));
          check("ofl", int'(o_ofl_s), int'(e[17:16]));
        end
      end else if (o_valid_s && !i_ready) begin
        held_man = o_man_s;
        held_ofl = o_ofl_s;
        hold_pending = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1; i_valid = 0; i_num = '0; i_mode = 2'd0; i_seed_vld = 0; i_seed = '0; i_ready = 1;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_valid", int'(o_valid_s), 0);
    check("reset_man", int'(o_man_s), 0);
    check("reset_ofl", int'(o_ofl_s), 0);
    @(posedge clk);
    #1;
    i_rst = 0;

    // Truncate
    drive(1, {8'h4F, 8'h5A}, 2'd0, 0, '0, 1);
    // Half-up then nearest-even, back to back
    drive(1, {8'h58, 8'h58}, 2'd1, 0, '0, 1);
    drive(1, {8'h58, 8'h48}, 2'd3, 0, '0, 1);
    drive(1, {8'h00, 8'h49}, 2'd3, 0, '0, 1);
    idle(2);

    // Stochastic from reset seeds, then again with advanced LFSRs
    pulse_reset();
    drive(1, {8'h5E, 8'h5F}, 2'd2, 0, '0, 1);
    drive(1, {8'h5E, 8'h5F}, 2'd2, 0, '0, 1);
    idle(1);

    // Overflow: saturate vs wrap
    drive(1, {8'hF8, 8'hF8}, 2'd1, 0, '0, 1);
    drive(1, {8'h00, 8'hFF}, 2'd3, 0, '0, 1);
    idle(1);

    // Backpressure for 5 cycles with a pending beat
    drive(1, {8'h13, 8'h37}, 2'd2, 0, '0, 1);
    for (int i = 0; i < 5; i++) drive(1, {8'h2F, 8'h1F}, 2'd2, 0, '0, 0);
    drive(1, {8'h2F, 8'h1F}, 2'd2, 0, '0, 1);
    drive(1, {8'h7E, 8'h6D}, 2'd2, 0, '0, 1);
    idle(1);

    // Seed load with zero seed on an accept, then use of the loaded seeds
    drive(1, {8'h11, 8'h22}, 2'd2, 1, 4'h0, 1);
    drive(1, {8'h5E, 8'h5F}, 2'd2, 0, '0, 1);
    drive(1, {8'h3C, 8'h9A}, 2'd2, 1, 4'hB, 1);
    drive(1, {8'h3C, 8'h9A}, 2'd2, 0, '0, 1);

    // Reset while a beat is held
    drive(1, {8'hAA, 8'h55}, 2'd1, 0, '0, 0);
    drive(1, {8'hBB, 8'h66}, 2'd1, 0, '0, 0);
    pulse_reset();
    drive(1, {8'h5E, 8'h5F}, 2'd2, 0, '0, 1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [LANES*WI-1:0] n;
      logic [NW-1:0]       sd;
      n  = LANES*WI'($urandom);
      sd = NW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sd = '0;
      drive(($urandom_range(0, 3) != 0), n, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0), sd, ($urandom_range(0, 9) < 7));
    end

    idle(3);
    check("drain_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
